// File: rtl/cpu_defs.sv
// Shared controller state codes, interrupt source indices
// and interrupt-gate FSM states.
package cpu_defs;

  localparam logic [4:0] CS_IF   = 5'h00;
  localparam logic [4:0] CS_WEPC = 5'h12;
  localparam logic [4:0] CS_RET  = 5'h16;

  localparam int SRC_KBD = 1;
  localparam int SRC_CNT = 0;

  typedef logic [2:0] irq_st_t;

  localparam irq_st_t S_IDLE  = 3'd0;
  localparam irq_st_t S_REQ   = 3'd1;
  localparam irq_st_t S_GRANT = 3'd2;
  localparam irq_st_t S_SERV  = 3'd3;
  localparam irq_st_t S_DRAIN = 3'd4;

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchronizer followed by a registered
// rising-edge pulse.
module irq_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sq;
  logic              lvl_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq    <= '0;
      lvl_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sq    <= {sq[STAGES-2:0], din};
      lvl_q <= sq[STAGES-1];
      pulse <= sq[STAGES-1] & ~lvl_q;
    end
  end

endmodule

// File: rtl/irq_gate.sv
// Interrupt front-end: sync/edge-detect, pending latches,
// mask, and grant tracking around the controller trap flow.
import cpu_defs::*;

module irq_gate #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] MASK_RST    = 2'b11,
  parameter logic [4:0] ST_IF       = CS_IF,
  parameter logic [4:0] ST_WEPC     = CS_WEPC,
  parameter logic [4:0] ST_RET      = CS_RET
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbd_req,
  input  logic       cnt_req,
  input  logic [4:0] state_in,
  input  logic       mask_we,
  input  logic [1:0] mask_din,
  output logic       INT_KBD,
  output logic       INT_CNT,
  output logic [1:0] pending,
  output logic [1:0] mask,
  output logic [1:0] overrun,
  output logic [1:0] grant_id
);

  logic    ev_k;
  logic    ev_c;
  logic [1:0] ev;
  logic [1:0] clr;
  logic [1:0] pend_nxt;
  logic [1:0] mask_nxt;
  logic [1:0] req_n;
  irq_st_t fsm;

  irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_kbd (
    .clk   (clk),
    .reset (reset),
    .din   (kbd_req),
    .pulse (ev_k)
  );

  irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cnt (
    .clk   (clk),
    .reset (reset),
    .din   (cnt_req),
    .pulse (ev_c)
  );

  // A new edge in the clearing cycle wins, so it is never lost.
  always_comb begin
    ev = '0;
    ev[SRC_KBD] = ev_k;
    ev[SRC_CNT] = ev_c;
    clr = (fsm == S_GRANT) ? grant_id : 2'b00;
    pend_nxt = (pending & ~clr) | ev;
    mask_nxt = mask_we ? mask_din : mask;
    req_n = '0;
    req_n[SRC_KBD] = pend_nxt[SRC_KBD] & mask_nxt[SRC_KBD];
    req_n[SRC_CNT] = pend_nxt[SRC_CNT] & mask_nxt[SRC_CNT]
                   & ~req_n[SRC_KBD];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      mask     <= MASK_RST;
      overrun  <= '0;
      grant_id <= '0;
      INT_KBD  <= 1'b0;
      INT_CNT  <= 1'b0;
      fsm      <= S_IDLE;
    end else begin
      pending <= pend_nxt;
      mask    <= mask_nxt;
      if (mask_we)
        overrun <= '0;
      else
        overrun <= overrun | (ev & pending & ~clr);
      INT_KBD <= 1'b0;
      INT_CNT <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (|req_n) begin
            fsm     <= S_REQ;
            INT_KBD <= req_n[SRC_KBD];
            INT_CNT <= req_n[SRC_CNT];
          end
        end
        S_REQ: begin
          if (state_in == ST_WEPC) begin
            grant_id <= {INT_KBD, INT_CNT};
            fsm      <= S_GRANT;
          end else if (!(|req_n)) begin
            fsm <= S_IDLE;
          end else begin
            INT_KBD <= req_n[SRC_KBD];
            INT_CNT <= req_n[SRC_CNT];
          end
        end
        S_GRANT: fsm <= S_SERV;
        S_SERV: begin
          if (state_in == ST_RET)
            fsm <= S_DRAIN;
        end
        S_DRAIN: begin
          if (state_in == ST_IF) begin
            grant_id <= '0;
            fsm      <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_gate.sv
// Directed bench for irq_gate: request, grant, priority,
// mask, overrun and async reset.
module tb_irq_gate;

  logic       clk;
  logic       reset;
  logic       kbd_req;
  logic       cnt_req;
  logic [4:0] state_in;
  logic       mask_we;
  logic [1:0] mask_din;
  logic       INT_KBD;
  logic       INT_CNT;
  logic [1:0] pending;
  logic [1:0] mask;
  logic [1:0] overrun;
  logic [1:0] grant_id;

  int total = 0;
  int bad   = 0;

  irq_gate dut (
    .clk      (clk),
    .reset    (reset),
    .kbd_req  (kbd_req),
    .cnt_req  (cnt_req),
    .state_in (state_in),
    .mask_we  (mask_we),
    .mask_din (mask_din),
    .INT_KBD  (INT_KBD),
    .INT_CNT  (INT_CNT),
    .pending  (pending),
    .mask     (mask),
    .overrun  (overrun),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mwr(input logic [1:0] v);
    mask_we  = 1'b1;
    mask_din = v;
    tick();
    mask_we  = 1'b0;
  endtask

  // WEPC -> GRANT -> SERVICE -> RET -> DRAIN -> IF -> IDLE
  task automatic serve();
    state_in = 5'h12; tick();
    state_in = 5'h00; tick();
    state_in = 5'h16; tick();
    state_in = 5'h00; tick();
  endtask

  initial begin
    reset    = 1'b1;
    kbd_req  = 1'b0;
    cnt_req  = 1'b0;
    state_in = 5'h00;
    mask_we  = 1'b0;
    mask_din = 2'b00;
    ticks(2);
    chk("rst_int", {6'd0, INT_KBD, INT_CNT}, 8'h0);
    chk("rst_pend", {6'd0, pending}, 8'h0);
    chk("rst_mask", {6'd0, mask}, 8'h3);
    chk("rst_ovr", {6'd0, overrun}, 8'h0);
    chk("rst_gnt", {6'd0, grant_id}, 8'h0);
    reset = 1'b0;
    tick();

    kbd_req = 1'b1;
    ticks(3);
    chk("k_early", {7'd0, INT_KBD}, 8'h0);
    tick();
    chk("k_int", {6'd0, INT_KBD, INT_CNT}, 8'h2);
    chk("k_pend", {6'd0, pending}, 8'h2);

    state_in = 5'h12; tick();
    chk("k_gnt", {6'd0, grant_id}, 8'h2);
    chk("k_gnt_int", {7'd0, INT_KBD}, 8'h0);
    state_in = 5'h00; tick();
    chk("k_clr", {6'd0, pending}, 8'h0);
    state_in = 5'h16; tick();
    state_in = 5'h00; tick();
    chk("k_drain", {6'd0, grant_id}, 8'h0);
    tick();
    chk("k_level", {7'd0, INT_KBD}, 8'h0);

    state_in = 5'h12; tick();
    chk("sys_wepc", {6'd0, grant_id}, 8'h0);
    state_in = 5'h00; tick();

    kbd_req = 1'b0;
    ticks(4);
    kbd_req = 1'b1;
    cnt_req = 1'b1;
    ticks(4);
    chk("both_int", {6'd0, INT_KBD, INT_CNT}, 8'h2);
    chk("both_pend", {6'd0, pending}, 8'h3);
    state_in = 5'h12; tick();
    chk("both_gnt", {6'd0, grant_id}, 8'h2);
    state_in = 5'h00; tick();
    chk("both_clr", {6'd0, pending}, 8'h1);
    chk("both_srv", {7'd0, INT_CNT}, 8'h0);
    state_in = 5'h16; tick();
    state_in = 5'h00; tick();
    chk("c_wait", {7'd0, INT_CNT}, 8'h0);
    tick();
    chk("c_int", {6'd0, INT_KBD, INT_CNT}, 8'h1);
    chk("c_pend", {6'd0, pending}, 8'h1);
    serve();
    tick();
    chk("c_done", {6'd0, pending}, 8'h0);

    mwr(2'b01);
    chk("m_val", {6'd0, mask}, 8'h1);
    kbd_req = 1'b0;
    ticks(4);
    kbd_req = 1'b1;
    ticks(4);
    chk("m_pend", {6'd0, pending}, 8'h2);
    chk("m_block", {7'd0, INT_KBD}, 8'h0);
    mwr(2'b11);
    chk("m_open", {7'd0, INT_KBD}, 8'h1);
    serve();
    tick();
    chk("m_done", {6'd0, pending}, 8'h0);

    cnt_req = 1'b0;
    ticks(4);
    cnt_req = 1'b1;
    ticks(4);
    chk("o_int", {7'd0, INT_CNT}, 8'h1);
    cnt_req = 1'b0;
    ticks(4);
    cnt_req = 1'b1;
    ticks(4);
    chk("o_ovr", {6'd0, overrun}, 8'h1);
    chk("o_pend", {6'd0, pending}, 8'h1);
    mwr(2'b11);
    chk("o_clr", {6'd0, overrun}, 8'h0);
    chk("o_int2", {7'd0, INT_CNT}, 8'h1);

    state_in = 5'h12; tick();
    chk("s_gnt", {6'd0, grant_id}, 8'h1);
    state_in = 5'h00; tick();
    mwr(2'b10);
    chk("s_mask", {6'd0, mask}, 8'h2);
    chk("s_gnt2", {6'd0, grant_id}, 8'h1);

    #2 reset = 1'b1;
    #1;
    chk("ar_int", {6'd0, INT_KBD, INT_CNT}, 8'h0);
    chk("ar_gnt", {6'd0, grant_id}, 8'h0);
    chk("ar_pend", {6'd0, pending}, 8'h0);
    chk("ar_mask", {6'd0, mask}, 8'h3);
    chk("ar_ovr", {6'd0, overrun}, 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
